mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branch/jump redirects and drives a handshaked data-memory port that can take more than one cycle.
- Stalls the upstream pipeline while a memory access is outstanding.
- Registers results into the MEM/WB boundary consumed by write-back.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting for dmem_ack before the access is aborted.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_RegWrite, in_Branch, in_MemtoReg, in_MemRead, in_MemWrite, in_Jump  in  1 each  control bits from EX/MEM
- in_opcode  in  6  opcode from EX/MEM
- in_zero  in  1  ALU zero flag
- in_pc_plus4  in  32  PC+4
- in_branch_target  in  32  branch target address
- in_jump_addr  in  32  jump target address
- in_alu_out  in  32  memory address or ALU result
- in_rd2  in  32  store data
- in_mux  in  5  destination register
- stall_o  out  1  hold IF/ID/EX and EX/MEM registers
- redirect_o  out  1  take new PC
- redirect_pc  out  32  new PC value
- flush_o  out  1  squash IF/ID/EX
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  memory address
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data
- dmem_ack  in  1  request accepted and completed
- mem_fault  out  1  one-cycle pulse: misaligned address, illegal control combination, or timeout
- wb_RegWrite  out  1  MEM/WB register write enable
- wb_MemtoReg  out  1  MEM/WB write-back select
- wb_read_data  out  32  MEM/WB load data
- wb_alu_out  out  32  MEM/WB ALU result
- wb_rd  out  5  MEM/WB destination register

Behaviour:
- Reset: async, active-high. FSM goes to IDLE, timeout counter to 0. Every registered output goes to 0: wb_*, dmem_req, dmem_we, mem_fault.
- mem_op = in_MemRead | in_MemWrite. A bubble is all controls 0.
- Alignment and control checks:
  - misaligned = mem_op & (in_alu_out[1:0] != 0).
  - MemRead and MemWrite both set counts as a fault.
  - A faulting op issues no request, pulses mem_fault for one cycle, and produces a MEM/WB bubble. No stall.
- FSM states IDLE, WAIT:
  - IDLE, legal mem_op: next cycle enter WAIT with dmem_req=1. dmem_we = in_MemWrite, dmem_addr = in_alu_out, dmem_wdata = in_rd2, all registered.
  - WAIT: hold dmem_req, dmem_we, dmem_addr, dmem_wdata stable until dmem_ack.
  - WAIT, dmem_ack=1: drop dmem_req next edge, return to IDLE, latch dmem_rdata into wb_read_data. Load WB controls from the inputs: RegWrite gated by MemRead, MemtoReg=1 for a load; both 0 for a store.
  - WAIT, counter reaches TIMEOUT_CYCLES without ack: drop dmem_req, pulse mem_fault, write a MEM/WB bubble, return to IDLE.
- Stall and latency:
  - stall_o (combinational) = (IDLE & legal mem_op) | (WAIT & ~dmem_ack & ~timeout).
  - A memory op with ack in its first WAIT cycle costs exactly 1 stall cycle.
  - In every stall cycle MEM/WB loads a bubble (wb_RegWrite=0); wb_read_data and wb_alu_out are left unchanged.
- Upstream contract: EX/MEM holds its outputs whenever stall_o=1.
- Non-memory ops: MEM/WB latches wb_RegWrite, wb_MemtoReg=0, wb_alu_out, wb_rd each cycle; 1-cycle latency.
- Redirect (combinational, only when stall_o=0):
  - take_br = in_Branch & ((in_opcode==6'h04 & in_zero) | (in_opcode==6'h05 & ~in_zero)).
  - redirect_o = take_br | in_Jump. redirect_pc = in_jump_addr when in_Jump, else in_branch_target. Jump has priority if both are set.
  - flush_o = redirect_o.
- Simultaneous events:
  - A dmem_ack arriving in IDLE is ignored.
  - A dmem_ack arriving in the same cycle the timeout is reached is a success; no fault.
  - Reset while in WAIT aborts the access immediately: dmem_req goes to 0 asynchronously.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B;
  - state encoding ST_IDLE, ST_WAIT;
  - the word-alignment mask.
- One natural sub-module, mem_wb_reg, holding the MEM/WB boundary with load and bubble inputs. Branch logic and the FSM stay in the top.

Test Plan:
- lw, in_alu_out=0x100, ack 3 cycles after req, rdata=0xDEADBEEF, in_mux=5 -> stall_o high for 3 cycles. wb_RegWrite=1, wb_MemtoReg=1, wb_read_data=0xDEADBEEF, wb_rd=5 one edge after ack.
- sw, addr 0x204, rd2=0x12345678, ack 1 cycle after req -> dmem_we=1 and stable address/data while req is high. One stall cycle; wb_RegWrite=0.
- beq with zero=1, target 0x40 -> redirect_o=1, redirect_pc=0x40, flush_o=1, same cycle. bne with zero=1 -> redirect_o=0.
- Jump=1 and Branch=1 taken together, jump_addr 0x80 -> redirect_pc=0x80.
- lw at addr 0x102 -> no dmem_req, mem_fault one cycle, wb_RegWrite=0, no stall. With TIMEOUT_CYCLES=4 and no ack -> mem_fault after 4 WAIT cycles, then IDLE.
- rst asserted mid-WAIT -> dmem_req=0 before the next edge, all wb_* are 0, state IDLE. After release, a fresh lw completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, MEM-stage FSM states,
// and the word-alignment mask.
package mips_pkg;

   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline boundary. A bubble clears the write-back controls
// but keeps the data fields so write-back never sees spurious values.
module mem_wb_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic        ld_rdata,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   input  logic [31:0] read_data,
   input  logic [31:0] alu_out,
   input  logic [4:0]  rd,
   output logic        wb_RegWrite,
   output logic        wb_MemtoReg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_alu_out,
   output logic [4:0]  wb_rd
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_RegWrite  <= 1'b0;
         wb_MemtoReg  <= 1'b0;
         wb_read_data <= '0;
         wb_alu_out   <= '0;
         wb_rd        <= '0;
      end else if (bubble) begin
         wb_RegWrite  <= 1'b0;
         wb_MemtoReg  <= 1'b0;
      end else begin
         wb_RegWrite  <= reg_write;
         wb_MemtoReg  <= mem_to_reg;
         wb_alu_out   <= alu_out;
         wb_rd        <= rd;
         if (ld_rdata)
            wb_read_data <= read_data;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch/jump redirect, handshaked data-memory access with
// timeout, upstream stall generation and MEM/WB register update.
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_RegWrite,
   input  logic        in_Branch,
   input  logic        in_MemtoReg,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_Jump,
   input  logic [5:0]  in_opcode,
   input  logic        in_zero,
   input  logic [31:0] in_pc_plus4,
   input  logic [31:0] in_branch_target,
   input  logic [31:0] in_jump_addr,
   input  logic [31:0] in_alu_out,
   input  logic [31:0] in_rd2,
   input  logic [4:0]  in_mux,
   output logic        stall_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc,
   output logic        flush_o,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_fault,
   output logic        wb_RegWrite,
   output logic        wb_MemtoReg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_alu_out,
   output logic [4:0]  wb_rd
);

   state_t          state, state_nxt;
   logic [TO_W-1:0] cnt;

   logic mem_op, misaligned, illegal, legal_op;
   logic in_idle, in_wait, timeout, fault_now, take_br;
   logic wb_bubble, wb_ld_rdata, wb_rw, wb_mtr;

   // Carried down the pipe for later stages; not needed here.
   logic unused_ok;
   assign unused_ok = ^{in_pc_plus4, in_MemtoReg};

   assign in_idle    = (state == ST_IDLE);
   assign in_wait    = (state == ST_WAIT);
   assign mem_op     = in_MemRead | in_MemWrite;
   assign misaligned = mem_op & ((in_alu_out[1:0] & ALIGN_MASK) != 2'b00);
   assign illegal    = mem_op & (misaligned | (in_MemRead & in_MemWrite));
   assign legal_op   = mem_op & ~illegal;
   assign timeout    = in_wait & (cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign fault_now  = (in_idle & illegal) | (timeout & ~dmem_ack);

   assign stall_o = (in_idle & legal_op)
                  | (in_wait & ~dmem_ack & ~timeout);

   assign take_br = in_Branch
                  & (((in_opcode == OP_BEQ) & in_zero)
                  |  ((in_opcode == OP_BNE) & ~in_zero));

   assign redirect_o  = ~stall_o & (take_br | in_Jump);
   assign redirect_pc = in_Jump ? in_jump_addr : in_branch_target;
   assign flush_o     = redirect_o;

   always_comb begin
      state_nxt   = state;
      wb_bubble   = 1'b1;
      wb_ld_rdata = 1'b0;
      wb_rw       = 1'b0;
      wb_mtr      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (legal_op) begin
               state_nxt = ST_WAIT;
            end else if (!illegal) begin
               wb_bubble = 1'b0;
               wb_rw     = in_RegWrite;
            end
         end
         ST_WAIT: begin
            if (dmem_ack) begin
               state_nxt   = ST_IDLE;
               wb_bubble   = 1'b0;
               wb_ld_rdata = 1'b1;
               wb_rw       = in_RegWrite & in_MemRead;
               wb_mtr      = in_MemRead;
            end else if (timeout) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (in_wait && !dmem_ack && !timeout)
         cnt <= cnt + 1'b1;
      else
         cnt <= '0;
   end

   // Request fields are launched once and held for the whole wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         mem_fault  <= 1'b0;
      end else begin
         mem_fault <= fault_now;
         if (in_idle && legal_op) begin
            dmem_req   <= 1'b1;
            dmem_we    <= in_MemWrite;
            dmem_addr  <= in_alu_out;
            dmem_wdata <= in_rd2;
         end else if (in_wait && (dmem_ack || timeout)) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
         end
      end
   end

   mem_wb_reg u_mem_wb (
      .clk          (clk),
      .rst          (rst),
      .bubble       (wb_bubble),
      .ld_rdata     (wb_ld_rdata),
      .reg_write    (wb_rw),
      .mem_to_reg   (wb_mtr),
      .read_data    (dmem_rdata),
      .alu_out      (in_alu_out),
      .rd           (in_mux),
      .wb_RegWrite  (wb_RegWrite),
      .wb_MemtoReg  (wb_MemtoReg),
      .wb_read_data (wb_read_data),
      .wb_alu_out   (wb_alu_out),
      .wb_rd        (wb_rd)
   );

endmodule
